// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op codes, FSM states
// and the operand magnitude helper.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Caller supplies the operand sign-extended to 64 bits when is_signed is set.
  function automatic logic [63:0] abs_val(input logic [63:0] value, input logic is_signed);
    return (is_signed && value[63]) ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready
// handshakes. Optional feature macro: DIV_EARLY_OUT_EN (skip CALC when |rdA| < |rdB|).
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rdA,
  input  logic [XLEN-1:0] rdB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             op_signed, op_rem, sgn_ovf;
  logic [63:0]      a_ext, b_ext;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN:0]    rem_sh, rem_n;
  logic [XLEN-1:0]  quo_n, quo_fix, rem_fix;
  logic             ge;

  assign op_signed = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
  assign op_rem    = (div_op == DIV_OP_REM) || (div_op == DIV_OP_REMU);
  assign sgn_ovf   = op_signed && (rdA == MIN_NEG) && (rdB == '1);

  assign a_ext = op_signed ? 64'(signed'(rdA)) : 64'(rdA);
  assign b_ext = op_signed ? 64'(signed'(rdB)) : 64'(rdB);
  assign mag_a = XLEN'(abs_val(a_ext, op_signed));
  assign mag_b = XLEN'(abs_val(b_ext, op_signed));

  // One restoring step: the shifted remainder is XLEN+1 bits so the compare never overflows.
  always_comb begin
    rem_sh  = (XLEN+1)'({rem_q, quo_q[XLEN-1]});
    ge      = rem_sh >= {1'b0, dvs_q};
    rem_n   = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_n   = {quo_q[XLEN-2:0], ge};
    quo_fix = neg_quo_q ? (~quo_n + 1'b1) : quo_n;
    rem_fix = XLEN'(rem_n);
    if (neg_rem_q) rem_fix = ~rem_fix + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            is_rem_d  = op_rem;
            neg_quo_d = op_signed && (rdA[XLEN-1] ^ rdB[XLEN-1]);
            neg_rem_d = op_signed && rdA[XLEN-1];
            rem_d     = '0;
            quo_d     = mag_a;
            dvs_d     = mag_b;
            cnt_d     = CNT_W'(XLEN);
            if (rdB == '0) begin
              result_d = op_rem ? rdA : '1;
              state_d  = S_DONE;
            end else if (sgn_ovf) begin
              result_d = op_rem ? '0 : rdA;
              state_d  = S_DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (mag_a < mag_b) begin
              result_d = op_rem ? rdA : '0;
              state_d  = S_DONE;
            end
`endif
            else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = is_rem_q ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, backpressure, flush/reset
// kill, and randomized ops against an integer-arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  div_op;
  logic [31:0] rdA, rdB, div_result;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_op(div_op),
    .rdA(rdA), .rdB(rdB),
    .out_valid(out_valid), .out_ready(out_ready),
    .div_result(div_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic            sg, is_rem;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    sg = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    is_rem = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sg) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic   sg;
    sg = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 32'd0) return 1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    sa = sg ? longint'(signed'(a)) : longint'(a);
    sb = sg ? longint'(signed'(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (sa < sb) return 1;
`else
    sa = 0;
    sb = 0;
`endif
    return 33;
  endfunction

  // Issue one op from IDLE with out_ready=1 and check latency, result and the 1-cycle pulse.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    div_op = op; rdA = a; rdB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, div_result, exp_res);
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    div_op = DIV_OP_DIV; rdA = '0; rdB = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", div_result, 32'd0);

    do_op("div 100/7",   DIV_OP_DIV,  32'd100, 32'd7, 32'd14, 33);
    do_op("rem 100/7",   DIV_OP_REM,  32'd100, 32'd7, 32'd2, 33);
    do_op("div -7/2",    DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem -7/2",    DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu big/2",  DIV_OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    do_op("remu 7/big",  DIV_OP_REMU, 32'd7, 32'hFFFF_FFFE, 32'd7,
          model_lat(DIV_OP_REMU, 32'd7, 32'hFFFF_FFFE));
    do_op("divu 5/0",    DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem 5/0",     DIV_OP_REM,  32'd5, 32'd0, 32'd5, 1);
    do_op("div 0/0",     DIV_OP_DIV,  32'd0, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("div ovf",     DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem ovf",     DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Backpressure: result held, new request ignored.
    out_ready = 1'b0;
    div_op = DIV_OP_DIV; rdA = 32'd100; rdB = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        div_op = DIV_OP_DIVU; rdA = 32'd50; rdB = 32'd5; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result", div_result, 32'd14);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release busy", 32'(busy), 32'd0);

    // Kill during CALC: first with flush, then with rst.
    for (int k = 0; k < 2; k++) begin
      div_op = DIV_OP_DIVU; rdA = 32'd1000; rdB = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      if (k == 0) flush = 1'b1; else rst = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; rst = 1'b0;
      check(k == 0 ? "flush in_ready" : "rst in_ready", 32'(in_ready), 32'd1);
      check(k == 0 ? "flush busy" : "rst busy", 32'(busy), 32'd0);
      if (k == 1) check("rst clears result", div_result, 32'd0);
      if (k == 0) begin
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush beats in_valid", 32'(busy), 32'd0);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check(k == 0 ? "flush no result" : "rst no result", 32'(seen), 32'd0);
      do_op(k == 0 ? "after flush divu 9/3" : "after rst divu 9/3",
            DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
    end

    // Flush while holding a result in DONE discards it.
    out_ready = 1'b0;
    div_op = DIV_OP_DIVU; rdA = 32'd5; rdB = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done held", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done flush out_valid", 32'(out_valid), 32'd0);
    check("done flush in_ready", 32'(in_ready), 32'd1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: ra = $urandom_range(0, 300);
        1: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_op("random", rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
